// File: rtl/regfile_wb_arbiter_if.sv
// Write-side bus bundle for regfile_wb_arbiter: pipeline writeback, long-latency
// result push channel and the register file write port.
interface regfile_wb_arbiter_if;
  logic        wb_we_i;
  logic [4:0]  wb_wa_i;
  logic [31:0] wd_pad_unused;
  logic [31:0] wb_wd_i;
  logic        lr_valid_i;
  logic [4:0]  lr_wa_i;
  logic [31:0] lr_wd_i;
  logic        lr_ready_o;
  logic        we3_o;
  logic [4:0]  wa3_o;
  logic [31:0] wd3_o;

  modport master (
    output wb_we_i, wb_wa_i, wb_wd_i, lr_valid_i, lr_wa_i, lr_wd_i,
    input  lr_ready_o, we3_o, wa3_o, wd3_o
  );

  modport slave (
    input  wb_we_i, wb_wa_i, wb_wd_i, lr_valid_i, lr_wa_i, lr_wd_i,
    output lr_ready_o, we3_o, wa3_o, wd3_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter: pipeline writeback first, buffered
// long-latency results fill idle cycles; tracks pending registers and starvation.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  regfile_wb_arbiter_if.slave  bus,
  input  logic                 iss_valid_i,
  input  logic [4:0]           iss_wa_i,
  input  logic [4:0]           ra1_i,
  input  logic [4:0]           ra2_i,
  output logic                 busy1_o,
  output logic                 busy2_o,
  output logic                 wb_stall_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [7:0]  STARVE_C = 8'(STARVE_MAX);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    age_q, age_d;
  logic [31:0]   pending_q, pending_d;

  entry_t      head;
  logic        fifo_empty;
  logic        lr_ready;
  logic        push;
  logic        pop;
  logic        wb_sel;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  // Push handshake: a result transfers on any edge where lr_valid_i && lr_ready_o.
  // lr_ready_o depends on the registered count only, so a full FIFO refuses a
  // push even in a cycle that also pops.
  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign lr_ready   = (count_q != DEPTH_C);
  assign push       = bus.lr_valid_i && lr_ready;
  assign wb_sel     = bus.wb_we_i && (bus.wb_wa_i != 5'd0);
  assign pop        = !wb_sel && !fifo_empty;

  assign bus.lr_ready_o = lr_ready;
  assign busy1_o        = pending_q[ra1_i];
  assign busy2_o        = pending_q[ra2_i];
  assign wb_stall_o     = (age_q == STARVE_C);

  always_comb begin
    bus.we3_o = 1'b0;
    bus.wa3_o = 5'd0;
    bus.wd3_o = 32'd0;
    if (wb_sel) begin
      bus.we3_o = 1'b1;
      bus.wa3_o = bus.wb_wa_i;
      bus.wd3_o = bus.wb_wd_i;
    end else if (!fifo_empty) begin
      // An r0 head is still popped, just never written.
      bus.we3_o = (head.wa != 5'd0);
      bus.wa3_o = head.wa;
      bus.wd3_o = head.wd;
    end
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    set_vec = '0;
    clr_vec = '0;
    if (iss_valid_i) set_vec[iss_wa_i] = 1'b1;
    if (pop)         clr_vec[head.wa]  = 1'b1;
    // Set after clear so a same-cycle reissue keeps the register pending.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;

    age_d = age_q;
    if (fifo_empty || pop) age_d = 8'd0;
    else if (age_q != STARVE_C) age_d = age_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      pending_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      age_q     <= age_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{wa: bus.lr_wa_i, wd: bus.lr_wd_i};
  end

endmodule
